// File: rtl/threediff_env_responder.sv
// Plant-side responder for the 12-in/32-out benchmark controller: turns the
// command vector into a condition vector with a timed "done" handshake on x4.
`timescale 1ns/1ps

module threediff_env_responder #(
    parameter int unsigned DELAY      = 3,
    parameter int unsigned CNT_W      = 8,
    parameter logic [31:0] START_MASK = 32'h0400_0000,
    parameter logic [11:0] LFSR_SEED  = 12'hACE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cmd,
    input  logic        cfg_we,
    input  logic [11:0] cfg_cond,
    input  logic        cfg_rnd,
    output logic [11:0] stat,
    output logic        busy,
    output logic        overrun,
    output logic [15:0] cmd_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(DELAY - 1);
    localparam logic [11:0]      STATIC_MASK = 12'hFF7;
    localparam logic [11:0]      DONE_BIT    = 12'h008;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [11:0]      r_cond;
    logic             r_rnd;
    logic [11:0]      r_lfsr;
    logic             r_overrun;
    logic [15:0]      r_cmd_count;
    logic             w_start;
    logic             w_lfsr_fb;
    logic             w_done;

    assign w_start   = |(cmd & START_MASK);
    assign w_lfsr_fb = r_lfsr[11] ^ r_lfsr[5] ^ r_lfsr[3] ^ r_lfsr[0];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = S_BUSY;
                    w_cnt_next   = CNT_LOAD;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_next = S_DONE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Outputs decode registers only, so reset clears them without a clock edge.
    always_comb begin
        busy   = (r_state == S_BUSY);
        w_done = (r_state == S_DONE);
        stat   = (r_rnd ? (r_lfsr & STATIC_MASK) : r_cond) | (w_done ? DONE_BIT : 12'h000);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cond <= '0;
            r_rnd  <= 1'b0;
        end else if (cfg_we) begin
            r_cond <= cfg_cond & STATIC_MASK;
            r_rnd  <= cfg_rnd;
        end
    end

    // Free-running regardless of r_rnd so the sequence is fixed relative to reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[10:0], w_lfsr_fb};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun   <= 1'b0;
            r_cmd_count <= '0;
        end else begin
            if (w_start && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            if ((cmd != '0) && (r_cmd_count != 16'hFFFF)) begin
                r_cmd_count <= r_cmd_count + 16'd1;
            end
        end
    end

    assign overrun   = r_overrun;
    assign cmd_count = r_cmd_count;

endmodule

// File: tb/tb_threediff_env_responder.sv
// Directed self-checking bench for threediff_env_responder (default parameters).
`timescale 1ns/1ps

module tb_threediff_env_responder;

    logic        clk;
    logic        rst;
    logic [31:0] cmd;
    logic        cfg_we;
    logic [11:0] cfg_cond;
    logic        cfg_rnd;
    logic [11:0] stat;
    logic        busy;
    logic        overrun;
    logic [15:0] cmd_count;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [31:0] START = 32'h0400_0000;

    threediff_env_responder dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd),
        .cfg_we   (cfg_we),
        .cfg_cond (cfg_cond),
        .cfg_rnd  (cfg_rnd),
        .stat     (stat),
        .busy     (busy),
        .overrun  (overrun),
        .cmd_count(cmd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] lfsr_next(input logic [11:0] v);
        return {v[10:0], v[11] ^ v[5] ^ v[3] ^ v[0]};
    endfunction

    // Reset asserted at a negedge and released at the next one.
    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        cmd      = '0;
        cfg_we   = 1'b0;
        cfg_cond = '0;
        cfg_rnd  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (stat !== 12'h000) $display("FAIL reset_stat: got %h want 000", stat); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else n_pass++;
        n_total++; if (cmd_count !== 16'h0) $display("FAIL reset_count: got %h want 0", cmd_count); else n_pass++;
        repeat (20) @(negedge clk);
        n_total++; if (stat !== 12'h000) $display("FAIL idle_stat: got %h want 000", stat); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (overrun !== 1'b0) $display("FAIL idle_overrun: got %b want 0", overrun); else n_pass++;
        n_total++; if (cmd_count !== 16'h0) $display("FAIL idle_count: got %h want 0", cmd_count); else n_pass++;
    endtask

    task automatic test_handshake();
        logic [11:0] exp_stat [5] = '{12'hFF7, 12'hFF7, 12'hFF7, 12'hFFF, 12'hFF7};
        logic        exp_busy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        cfg_we = 1'b1; cfg_cond = 12'hFFF; cfg_rnd = 1'b0;
        @(negedge clk);
        cfg_we = 1'b0; cfg_cond = 12'h000;
        n_total++; if (stat !== 12'hFF7) $display("FAIL hs_cfg_stat: got %h want FF7", stat); else n_pass++;
        cmd = START;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmd = '0;
            n_total++; if (stat !== exp_stat[i]) $display("FAIL hs_stat[%0d]: got %h want %h", i, stat, exp_stat[i]); else n_pass++;
            n_total++; if (busy !== exp_busy[i]) $display("FAIL hs_busy[%0d]: got %b want %b", i, busy, exp_busy[i]); else n_pass++;
        end
        n_total++; if (cmd_count !== 16'd1) $display("FAIL hs_count: got %0d want 1", cmd_count); else n_pass++;
        n_total++; if (overrun !== 1'b0) $display("FAIL hs_overrun: got %b want 0", overrun); else n_pass++;
    endtask

    task automatic test_overrun();
        logic exp_done [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic exp_ovr  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset();
        cmd = START;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmd = (i == 0) ? START : 32'h0;
            n_total++; if (stat[3] !== exp_done[i]) $display("FAIL ovr_done[%0d]: got %b want %b", i, stat[3], exp_done[i]); else n_pass++;
            n_total++; if (overrun !== exp_ovr[i]) $display("FAIL ovr_flag[%0d]: got %b want %b", i, overrun, exp_ovr[i]); else n_pass++;
        end
        repeat (10) @(negedge clk);
        n_total++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", overrun); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL ovr_idle_busy: got %b want 0", busy); else n_pass++;

        // Start arriving while in DONE: flagged, dropped, no re-arm.
        do_reset();
        cmd = START;
        repeat (3) begin
            @(negedge clk);
            cmd = '0;
        end
        @(negedge clk);
        n_total++; if (stat[3] !== 1'b1) $display("FAIL done_pulse: got %b want 1", stat[3]); else n_pass++;
        n_total++; if (overrun !== 1'b0) $display("FAIL done_pre_ovr: got %b want 0", overrun); else n_pass++;
        cmd = START;
        @(negedge clk);
        cmd = '0;
        n_total++; if (overrun !== 1'b1) $display("FAIL done_ovr: got %b want 1", overrun); else n_pass++;
        n_total++; if (stat[3] !== 1'b0) $display("FAIL done_exit: got %b want 0", stat[3]); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL done_no_rearm: got %b want 0", busy); else n_pass++;
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL done_no_rearm2: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_lfsr();
        logic [11:0] model;
        logic [11:0] exp;
        logic [11:0] seen_or;
        logic [11:0] seen_and;
        do_reset();
        model = 12'hACE;
        cfg_we = 1'b1; cfg_rnd = 1'b1; cfg_cond = 12'h5A5;
        seen_or  = 12'h000;
        seen_and = 12'hFFF;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cfg_we = 1'b0;
            model = lfsr_next(model);
            exp = model & 12'hFF7;
            n_total++; if (stat !== exp) $display("FAIL lfsr[%0d]: got %h want %h", i, stat, exp); else n_pass++;
            seen_or  = seen_or | stat;
            seen_and = seen_and & stat;
        end
        n_total++; if (seen_or[3] !== 1'b0) $display("FAIL lfsr_bit3: got %b want 0", seen_or[3]); else n_pass++;
        n_total++; if ((seen_or & ~seen_and) !== 12'hFF7) $display("FAIL lfsr_toggle: got %h want FF7", seen_or & ~seen_and); else n_pass++;
        // Switching back to the static register takes effect on the following cycle.
        cfg_we = 1'b1; cfg_rnd = 1'b0; cfg_cond = 12'h123;
        @(negedge clk);
        cfg_we = 1'b0;
        n_total++; if (stat !== 12'h123) $display("FAIL cfg_back: got %h want 123", stat); else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        cfg_we = 1'b1; cfg_cond = 12'h0F0;
        @(negedge clk);
        cfg_we = 1'b0;
        cmd = START;
        @(negedge clk);
        cmd = '0;
        @(negedge clk);
        n_total++; if (busy !== 1'b1) $display("FAIL ar_busy_pre: got %b want 1", busy); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL ar_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (stat !== 12'h000) $display("FAIL ar_stat: got %h want 000", stat); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_total++; if ({busy, stat[3]} !== 2'b00) $display("FAIL ar_quiet[%0d]: got %b want 00", i, {busy, stat[3]}); else n_pass++;
        end

        // Reset in the middle of the DONE cycle drops the pulse at once.
        cmd = START;
        repeat (4) begin
            @(negedge clk);
            cmd = '0;
        end
        n_total++; if (stat[3] !== 1'b1) $display("FAIL ar_done_pre: got %b want 1", stat[3]); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if (stat[3] !== 1'b0) $display("FAIL ar_done: got %b want 0", stat[3]); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        cmd = 32'h0000_0001;
        for (int k = 1; k <= 70000; k++) begin
            @(negedge clk);
            if (k == 65534) begin
                n_total++; if (cmd_count !== 16'hFFFE) $display("FAIL sat_pre: got %h want FFFE", cmd_count); else n_pass++;
            end
            if (k == 65535) begin
                n_total++; if (cmd_count !== 16'hFFFF) $display("FAIL sat_hit: got %h want FFFF", cmd_count); else n_pass++;
            end
        end
        n_total++; if (cmd_count !== 16'hFFFF) $display("FAIL sat_hold: got %h want FFFF", cmd_count); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL sat_no_start: got %b want 0", busy); else n_pass++;
        cmd = '0;
    endtask

    initial begin
        rst      = 1'b1;
        cmd      = '0;
        cfg_we   = 1'b0;
        cfg_cond = '0;
        cfg_rnd  = 1'b0;
        test_reset();
        test_handshake();
        test_overrun();
        test_lfsr();
        test_async_reset();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
